// File: rtl/dmem_arbiter.sv
// Round-robin arbiter letting four cores share one single-port synchronous data RAM.
// Every output is a register, so nothing from req* reaches an output combinationally.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [3:0]    req_we,
  input  logic [4*AW-1:0] req_addr,
  input  logic [4*DW-1:0] req_wdata,
  output logic [3:0]    gnt,
  output logic [3:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state, state_n;
  logic [1:0]    last, last_n;
  logic [1:0]    cur, cur_n;
  logic          cur_we, cur_we_n;
  logic [3:0]    gnt_n, rvalid_n;
  logic [DW-1:0] rdata_n;
  logic          mem_en_n, mem_we_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n;

  logic [3:0]    req_m;
  logic          found;
  logic [1:0]    win, idx;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          start;

  // The port just issued is masked in RESP: its req is still up while it sees gnt.
  always_comb begin
    req_m = req;
    if (state == RESP) req_m[cur] = 1'b0;
    found = 1'b0;
    win   = last;
    idx   = last;
    for (int j = 1; j <= 4; j++) begin
      idx = last + 2'(j);
      if (!found && req_m[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (win == 2'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_n     = state;
    last_n      = last;
    cur_n       = cur;
    cur_we_n    = cur_we;
    gnt_n       = 4'b0000;
    rvalid_n    = 4'b0000;
    rdata_n     = rdata;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    start       = 1'b0;
    case (state)
      IDLE: begin
        start = found;
      end
      ISSUE: begin
        state_n = cur_we ? IDLE : RESP;
      end
      RESP: begin
        rdata_n  = mem_rdata;
        rvalid_n = 4'b0001 << cur;
        state_n  = IDLE;
        start    = found;
      end
      default: state_n = IDLE;
    endcase
    // The issue-cycle outputs are registered together with the move into ISSUE.
    if (start) begin
      state_n     = ISSUE;
      last_n      = win;
      cur_n       = win;
      cur_we_n    = sel_we;
      gnt_n       = 4'b0001 << win;
      mem_en_n    = 1'b1;
      mem_we_n    = sel_we;
      mem_addr_n  = sel_addr;
      mem_wdata_n = sel_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 2'd3;
      cur       <= 2'd0;
      cur_we    <= 1'b0;
      gnt       <= 4'b0000;
      rvalid    <= 4'b0000;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      cur       <= cur_n;
      cur_we    <= cur_we_n;
      gnt       <= gnt_n;
      rvalid    <= rvalid_n;
      rdata     <= rdata_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: RAM model, per-cycle tick with read scoreboard, linear test steps.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int W  = 4 + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0;
  logic [3:0]    req_we = '0;
  logic [4*AW-1:0] req_addr = '0;
  logic [4*DW-1:0] req_wdata = '0;
  logic [3:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          busy, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] ram [256];
  logic [W-1:0]  exp_q [$];
  logic [3:0]    sticky = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pre(input int a);
    return 16'hC300 + 16'(a);
  endfunction

  initial for (int i = 0; i < 256; i++) ram[i] = pre(i);

  // single-port synchronous RAM
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic drive(input int core, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[core] = we;
    req_addr[core*AW +: AW] = a;
    req_wdata[core*DW +: DW] = d;
    req[core] = 1'b1;
  endtask

  // one cycle: sample at negedge, scoreboard any read response, drop granted requests
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    if (rvalid !== 4'b0000) begin
      if (exp_q.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rvalid_port", 32'(rvalid), 32'(e[W-1:DW]));
        chk("rdata", 32'(rdata), 32'(e[DW-1:0]));
      end
    end
    req = req & ~(gnt & ~sticky);
  endtask

  initial begin
    int grants;
    logic got3, prev0, rep0;
    logic [3:0] eg, er;

    // reset state
    repeat (2) tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    rst = 1'b0;

    // test 1: reset during ISSUE of a read; its response must never appear
    tick();
    drive(1, 1'b0, 8'h20, 16'h0000);
    tick();
    chk("t1_gnt_pre", 32'(gnt), 32'h2);
    chk("t1_mem_en_pre", 32'(mem_en), 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_mem_en_rst", 32'(mem_en), 0);
    chk("t1_gnt_rst", 32'(gnt), 0);
    chk("t1_busy_rst", 32'(busy), 0);
    req = '0;
    tick();
    rst = 1'b0;
    drive(0, 1'b0, 8'h22, 16'h0000);
    exp_q.push_back({4'b0001, pre(8'h22)});
    tick();
    chk("t1_gnt_after", 32'(gnt), 32'h1);
    repeat (4) tick();
    chk("t1_drained", exp_q.size(), 0);

    // test 2: single write from core 2
    drive(2, 1'b1, 8'h10, 16'hBEEF);
    tick();
    chk("t2_gnt", 32'(gnt), 32'h4);
    chk("t2_mem_en", 32'(mem_en), 1);
    chk("t2_mem_we", 32'(mem_we), 1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h10);
    chk("t2_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    tick();
    chk("t2_idle", 32'(busy), 0);
    chk("t2_gnt_pulse", 32'(gnt), 0);

    // test 3: core 1 reads back the written word
    drive(1, 1'b0, 8'h10, 16'h0000);
    exp_q.push_back({4'b0010, 16'hBEEF});
    tick();
    chk("t3_gnt", 32'(gnt), 32'h2);
    chk("t3_mem_we", 32'(mem_we), 0);
    chk("t3_mem_addr", 32'(mem_addr), 32'h10);
    tick();
    chk("t3_busy_resp", 32'(busy), 1);
    chk("t3_rvalid_early", 32'(rvalid), 0);
    tick();
    chk("t3_rvalid", 32'(rvalid), 32'h2);
    chk("t3_drained", exp_q.size(), 0);

    // test 4: all four cores read at once straight from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(c, 1'b0, 8'(8'h20 + c), 16'h0000);
      exp_q.push_back({4'(1 << c), pre(8'h20 + c)});
    end
    for (int t = 1; t <= 9; t++) begin
      tick();
      eg = (t % 2 == 1 && t <= 7) ? 4'(1 << ((t - 1) / 2)) : 4'b0000;
      er = (t % 2 == 1 && t >= 3) ? 4'(1 << ((t - 3) / 2)) : 4'b0000;
      chk($sformatf("t4_gnt_c%0d", t), 32'(gnt), 32'(eg));
      chk($sformatf("t4_rvalid_c%0d", t), 32'(rvalid), 32'(er));
    end
    chk("t4_drained", exp_q.size(), 0);

    // test 5: core 0 requests continuously, core 3 requests once
    sticky = 4'b0001;
    drive(0, 1'b1, 8'h30, 16'h1234);
    repeat (4) tick();
    drive(3, 1'b0, 8'h21, 16'h0000);
    exp_q.push_back({4'b1000, pre(8'h21)});
    grants = 0; got3 = 1'b0; prev0 = 1'b0; rep0 = 1'b0;
    for (int t = 0; t < 12 && !got3; t++) begin
      tick();
      if (gnt !== 4'b0000) begin
        grants++;
        if (gnt[0] && prev0) rep0 = 1'b1;
        prev0 = gnt[0];
        if (gnt[3]) got3 = 1'b1;
      end
    end
    chk("t5_core3_granted", 32'(got3), 1);
    chk("t5_within_2", 32'(grants <= 2), 1);
    chk("t5_no_core0_repeat", 32'(rep0), 0);
    sticky = 4'b0000;
    req = '0;
    repeat (5) tick();
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_core0_write", 32'(ram[8'h30]), 32'h1234);

    // test 6: idle for 20 cycles
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("t6_gnt", 32'(gnt), 0);
      chk("t6_rvalid", 32'(rvalid), 0);
      chk("t6_mem_en", 32'(mem_en), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_rdata_hold", 32'(rdata), 32'(pre(8'h21)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
